data_expand: RTL and testbench
==============================

Name: data_expand

Overview:
- Inverse of the DFE output rounding stage: takes narrow signed samples from the DFE datapath and re-expands them to a wide signed accumulator format.
- Applies a programmable arithmetic left shift (power-of-two gain) with saturation.
- Ready/valid handshake on both sides; 2-entry output skid buffer.
- Saturation event counter for host readback. Sits at the DFE input, ahead of the wide filter/accumulator chain.

Parameters:
- DIN_WIDTH, 17, input sample width, signed two's complement.
- DOUT_WIDTH, 39, output sample width, signed; must be > DIN_WIDTH.
- SHIFT_WIDTH, 6, width of shift control.
- CNT_WIDTH, 16, saturation counter width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_shift  in  SHIFT_WIDTH  requested left-shift amount.
- i_shift_load  in  1  single-cycle strobe; captures i_shift.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept input.
- i_data  in  DIN_WIDTH  input sample.
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts output.
- o_data  out  DOUT_WIDTH  expanded sample.
- o_sat  out  1  qualifies o_data: this sample was saturated.
- i_sat_clr  in  1  synchronous clear of o_sat_cnt.
- o_sat_cnt  out  CNT_WIDTH  count of saturated samples accepted downstream.

Behaviour:
- Reset state: all outputs 0, except o_ready = 1. shift_active = 0, skid buffer empty.
- Reset is asynchronous. Reset mid-operation discards all buffered samples.
- Shift control:
  - On i_shift_load = 1, shift_active <= min(i_shift, DOUT_WIDTH-1) on the next edge.
  - The new shift applies to samples accepted from the following cycle on.
  - A sample accepted in the same cycle as the load uses the old value.
- Input transfer: occurs when i_valid & o_ready. Output transfer: occurs when o_valid & i_ready.
- Arithmetic:
  - Sign-extend i_data to DOUT_WIDTH+DIN_WIDTH bits, then shift left by shift_active. The intermediate width guarantees no bits are lost.
  - If the intermediate value exceeds the signed DOUT_WIDTH range, saturate to 2^(DOUT_WIDTH-1)-1 or -2^(DOUT_WIDTH-1), and set o_sat for that sample.
  - Saturation is possible only when shift_active > DOUT_WIDTH-DIN_WIDTH.
  - An exact minimum value (e.g. -2^16 << 22 = -2^38) is not saturation.
- Pipeline: one register stage (output register) plus one skid register.
  - Latency: sample accepted at edge N is presented on o_data/o_valid after edge N, visible in cycle N+1, when no stall.
  - Throughput: 1 sample/clk while i_ready = 1.
- Buffer rules:
  - Output register empty or draining this cycle: the new sample loads the output register.
  - Output register full and stalled: the new sample goes to the skid register, and o_ready <= 0 at the next edge.
  - When the output register drains, the skid contents move to the output register and o_ready <= 1.
  - o_ready is a registered output with no combinational path from i_ready.
  - No sample is lost or duplicated; order is preserved.
- o_data and o_sat are held stable while o_valid = 1 and i_ready = 0.
- Saturation counter:
  - Increments on each output transfer with o_sat = 1.
  - Holds at all-ones; does not wrap.
  - If i_sat_clr and an increment occur in the same cycle, clear wins and the result is 0.

Test Plan:
- Shift 0, i_data = 0x1FFFF (-1) -> o_data = 0x7FFFFFFFFF, o_sat = 0. o_valid rises one cycle after acceptance.
- Shift 22:
  - i_data = 0x00001 -> o_data = 0x0000400000.
  - i_data = 0x10000 -> o_data = 0x4000000000, o_sat = 0 (exact minimum).
- Shift 23:
  - i_data = 0x0FFFF -> o_data = 0x3FFFFFFFFF, o_sat = 1, o_sat_cnt = 1.
  - i_data = 0x10000 -> o_data = 0x4000000000, o_sat = 1, o_sat_cnt = 2.
  - Then pulse i_sat_clr in the same cycle as a saturated transfer -> o_sat_cnt = 0.
- Shift load with i_shift = 63 -> shift_active clamps to 38. i_data = 0x00001 -> o_data = 0x4000000000 (the 1 lands in the sign bit), so it saturates to 0x3FFFFFFFFF with o_sat = 1.
- Backpressure: stream values 1, 2, 3, 4 with i_valid = 1 and i_ready = 0 for 3 cycles.
  - o_ready drops after 2 samples are held.
  - After i_ready = 1, the outputs are 1, 2, 3, 4 in order, with no gaps once streaming.
- Assert i_rst_n = 0 while both buffer entries are full -> o_valid = 0, o_ready = 1, o_sat_cnt = 0. After release, the first new sample passes with 1-cycle latency.

Source files
------------

// File: rtl/data_expand_if.sv
// Handshake bundle for data_expand.
//   slave  : the expander (consumes i_valid/i_data/i_ready, drives o_ready/o_valid/o_data/o_sat)
//   master : the surrounding logic that feeds and drains it
// Signal names match the original flat ports of data_expand.
interface data_expand_if #(
  parameter int DIN_WIDTH  = 17,
  parameter int DOUT_WIDTH = 39
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DIN_WIDTH-1:0]  i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [DOUT_WIDTH-1:0] o_data;
  logic                  o_sat;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_sat
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_sat
  );
endinterface

// File: rtl/data_expand.sv
// data_expand: re-expands narrow signed DFE samples into the wide signed
// accumulator format with a programmable power-of-two gain and saturation.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_shift/_load      : left-shift amount, captured (clamped) on the load strobe
//   bus (slave)        : input ready/valid + i_data, output ready/valid + o_data/o_sat
//   i_sat_clr          : synchronous clear of the saturation counter
//   o_sat_cnt          : saturated samples accepted downstream (sticks at all-ones)
// One output register plus one skid register; o_ready is registered.
module data_expand #(
  parameter int DIN_WIDTH   = 17,
  parameter int DOUT_WIDTH  = 39,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic                   i_shift_load,
  data_expand_if.slave           bus,
  input  logic                   i_sat_clr,
  output logic [CNT_WIDTH-1:0]   o_sat_cnt
);

  localparam int IW = DOUT_WIDTH + DIN_WIDTH;
  localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = SHIFT_WIDTH'(DOUT_WIDTH - 1);
  localparam logic [DOUT_WIDTH-1:0]  POS_SAT   = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0]  NEG_SAT   = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic [SHIFT_WIDTH-1:0] shift_active_q, shift_active_d;
  logic                   out_valid_q, out_valid_d;
  logic [DOUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [DOUT_WIDTH-1:0]  skid_data_q, skid_data_d;
  logic                   skid_sat_q, skid_sat_d;
  logic                   ready_q, ready_d;
  logic [CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;

  logic [IW-1:0]          shifted;
  logic [IW-DOUT_WIDTH:0] top_bits;
  logic [DOUT_WIDTH-1:0]  new_data;
  logic                   new_sat;
  logic                   in_fire;
  logic                   out_fire;

  assign in_fire  = bus.i_valid & ready_q;
  assign out_fire = out_valid_q & bus.i_ready;

  // Expansion: the intermediate is wide enough that the shift never drops bits;
  // the value fits the output iff every bit from the output sign bit upward agrees.
  always_comb begin
    shifted  = {{DOUT_WIDTH{bus.i_data[DIN_WIDTH-1]}}, bus.i_data} << shift_active_q;
    top_bits = shifted[IW-1:DOUT_WIDTH-1];
    new_sat  = !((&top_bits) || !(|top_bits));
    if (!new_sat)
      new_data = shifted[DOUT_WIDTH-1:0];
    else if (shifted[IW-1])
      new_data = NEG_SAT;
    else
      new_data = POS_SAT;
  end

  always_comb begin
    shift_active_d = shift_active_q;
    if (i_shift_load)
      shift_active_d = (i_shift > SHIFT_MAX) ? SHIFT_MAX : i_shift;
  end

  // Output register refills from the skid entry first (older sample), otherwise
  // from the input; a stalled output register diverts the input into the skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sat_d   = skid_sat_q;
    if (!out_valid_q || bus.i_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sat_d    = skid_sat_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = new_data;
        out_sat_d   = new_sat;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = new_data;
      skid_sat_d   = new_sat;
    end
    ready_d = !skid_valid_d;
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (i_sat_clr)
      sat_cnt_d = '0;
    else if (out_fire && out_sat_q && !(&sat_cnt_q))
      sat_cnt_d = sat_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_active_q <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sat_q      <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_data_q    <= '0;
      skid_sat_q     <= 1'b0;
      ready_q        <= 1'b1;
      sat_cnt_q      <= '0;
    end else begin
      shift_active_q <= shift_active_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sat_q      <= out_sat_d;
      skid_valid_q   <= skid_valid_d;
      skid_data_q    <= skid_data_d;
      skid_sat_q     <= skid_sat_d;
      ready_q        <= ready_d;
      sat_cnt_q      <= sat_cnt_d;
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = out_valid_q;
  assign bus.o_data   = out_data_q;
  assign bus.o_sat    = out_sat_q;
  assign o_sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_data_expand.sv
// Self-checking bench for data_expand: directed vectors, backpressure,
// mid-operation reset and a randomized run against an arithmetic reference model.
module tb_data_expand;

  typedef struct packed {
    logic        sat;
    logic [38:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  shift;
  logic        shift_load;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  data_expand_if #(.DIN_WIDTH(17), .DOUT_WIDTH(39)) bus ();

  data_expand #(
    .DIN_WIDTH(17), .DOUT_WIDTH(39), .SHIFT_WIDTH(6), .CNT_WIDTH(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_shift(shift), .i_shift_load(shift_load),
    .bus(bus), .i_sat_clr(sat_clr), .o_sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  int          shift_m;
  int unsigned cnt_m;
  int          unexp_cnt;
  exp_t        exp_q[$];
  exp_t        chk_e[$];
  exp_t        chk_o[$];

  // Reference: value * 2^shift in plain 64-bit arithmetic, clipped to the 39-bit signed range.
  function automatic exp_t model(logic [16:0] din, int sh);
    longint v, maxv, minv;
    exp_t r;
    maxv = (longint'(1) <<< 38) - 1;
    minv = -(longint'(1) <<< 38);
    v = longint'($signed(din)) * (longint'(1) <<< sh);
    r.sat = 1'b0;
    if (v > maxv) begin r.sat = 1'b1; v = maxv; end
    else if (v < minv) begin r.sat = 1'b1; v = minv; end
    r.data = v[38:0];
    return r;
  endfunction

  // Advance one clock, updating the reference model with whatever transfers
  // happen at this edge. Inputs are driven #1 after the edge.
  task automatic step();
    bit   inf, outf;
    exp_t e;
    inf  = bus.i_valid && bus.o_ready;
    outf = bus.o_valid && bus.i_ready;
    e = '0;
    if (outf) begin
      if (exp_q.size() == 0) unexp_cnt++;
      else begin
        e = exp_q.pop_front();
        chk_e.push_back(e);
        chk_o.push_back({bus.o_sat, bus.o_data});
      end
    end
    if (sat_clr) cnt_m = 0;
    else if (outf && e.sat && cnt_m != 65535) cnt_m++;
    if (inf) exp_q.push_back(model(bus.i_data, shift_m));
    if (shift_load) shift_m = (int'(shift) > 38) ? 38 : int'(shift);
    @(posedge clk); #1;
  endtask

  task automatic load_shift(input int s);
    shift = 6'(s); shift_load = 1'b1;
    step();
    shift_load = 1'b0;
  endtask

  task automatic xfer(input logic [16:0] d);
    bus.i_valid = 1'b1; bus.i_data = d;
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_data !== '0 ||
        bus.o_sat !== 1'b0 || sat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b data=%h sat=%b cnt=%0d, need 0/1/0/0/0",
               bus.o_valid, bus.o_ready, bus.o_data, bus.o_sat, sat_cnt);
    end
  endtask

  task automatic test_arith();
    bus.i_ready = 1'b1;
    load_shift(0);
    bus.i_valid = 1'b1; bus.i_data = 17'h1FFFF;
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_pre: o_valid=%b need 0", bus.o_valid);
    end
    step();
    bus.i_valid = 1'b0;
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 39'h7FFFFFFFFF || bus.o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL shift0_neg1: valid=%b data=%h sat=%b need 1/7fffffffff/0",
               bus.o_valid, bus.o_data, bus.o_sat);
    end

    load_shift(22);
    xfer(17'h00001);
    n_tests++;
    if (bus.o_data !== 39'h0000400000 || bus.o_sat !== 1'b0) begin
      n_fail++; $display("FAIL shift22_one: data=%h sat=%b need 0000400000/0", bus.o_data, bus.o_sat);
    end
    xfer(17'h10000);
    n_tests++;
    if (bus.o_data !== 39'h4000000000 || bus.o_sat !== 1'b0) begin
      n_fail++; $display("FAIL shift22_min: data=%h sat=%b need 4000000000/0", bus.o_data, bus.o_sat);
    end

    load_shift(23);
    xfer(17'h0FFFF);
    n_tests++;
    if (bus.o_data !== 39'h3FFFFFFFFF || bus.o_sat !== 1'b1) begin
      n_fail++; $display("FAIL shift23_pos: data=%h sat=%b need 3fffffffff/1", bus.o_data, bus.o_sat);
    end
    xfer(17'h10000);
    n_tests++;
    if (bus.o_data !== 39'h4000000000 || bus.o_sat !== 1'b1 || sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL shift23_neg: data=%h sat=%b cnt=%0d need 4000000000/1/1",
               bus.o_data, bus.o_sat, sat_cnt);
    end
    step();
    n_tests++;
    if (sat_cnt !== 16'd2) begin
      n_fail++; $display("FAIL sat_cnt_two: cnt=%0d need 2", sat_cnt);
    end
    xfer(17'h0FFFF);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    n_tests++;
    if (sat_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clr_wins: cnt=%0d need 0", sat_cnt);
    end

    load_shift(63);
    xfer(17'h00001);
    n_tests++;
    if (bus.o_data !== 39'h3FFFFFFFFF || bus.o_sat !== 1'b1) begin
      n_fail++; $display("FAIL clamp38: data=%h sat=%b need 3fffffffff/1", bus.o_data, bus.o_sat);
    end
    step();
    n_tests++;
    if (sat_cnt !== 16'd1) begin
      n_fail++; $display("FAIL clamp_cnt: cnt=%0d need 1", sat_cnt);
    end

    // Load and accept in the same cycle: the sample still sees shift 38.
    shift = 6'd0; shift_load = 1'b1; bus.i_valid = 1'b1; bus.i_data = 17'h00001;
    step();
    shift_load = 1'b0; bus.i_valid = 1'b0;
    n_tests++;
    if (bus.o_data !== 39'h3FFFFFFFFF || bus.o_sat !== 1'b1) begin
      n_fail++; $display("FAIL load_same_cycle: data=%h sat=%b need 3fffffffff/1", bus.o_data, bus.o_sat);
    end
    xfer(17'h00001);
    n_tests++;
    if (bus.o_data !== 39'h0000000001 || bus.o_sat !== 1'b0) begin
      n_fail++; $display("FAIL load_next_cycle: data=%h sat=%b need 0000000001/0", bus.o_data, bus.o_sat);
    end
    step();
    chk_e.delete(); chk_o.delete();
  endtask

  task automatic test_backpressure();
    exp_t o, e;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_data = 17'd1;
    step();
    bus.i_data = 17'd2;
    step();
    n_tests++;
    if (bus.o_ready !== 1'b0 || bus.o_data !== 39'd1) begin
      n_fail++; $display("FAIL bp_full: ready=%b data=%h need 0/1", bus.o_ready, bus.o_data);
    end
    bus.i_data = 17'd3;
    step();
    n_tests++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_data !== 39'd1) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b valid=%b data=%h need 0/1/1", bus.o_ready, bus.o_valid, bus.o_data);
    end
    bus.i_ready = 1'b1;
    step();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 39'd2 || bus.o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b data=%h ready=%b need 1/2/1", bus.o_valid, bus.o_data, bus.o_ready);
    end
    step();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 39'd3) begin
      n_fail++; $display("FAIL bp_stream3: valid=%b data=%h need 1/3", bus.o_valid, bus.o_data);
    end
    bus.i_data = 17'd4;
    step();
    bus.i_valid = 1'b0;
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 39'd4) begin
      n_fail++; $display("FAIL bp_stream4: valid=%b data=%h need 1/4", bus.o_valid, bus.o_data);
    end
    step();
    n_tests++;
    if (chk_o.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs need 4", chk_o.size());
    end
    while (chk_o.size() > 0) begin
      o = chk_o.pop_front(); e = chk_e.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL bp_order: got %h need %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_data = 17'd7;
    step();
    bus.i_data = 17'h0FFFF;
    step();
    bus.i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || sat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ready=%b cnt=%0d need 0/1/0", bus.o_valid, bus.o_ready, sat_cnt);
    end
    exp_q.delete(); chk_e.delete(); chk_o.delete();
    cnt_m = 0; shift_m = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    xfer(17'd5);
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 39'd5 || bus.o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first: valid=%b data=%h sat=%b need 1/5/0", bus.o_valid, bus.o_data, bus.o_sat);
    end
    step();
    chk_e.delete(); chk_o.delete();
  endtask

  task automatic test_random();
    exp_t o, e;
    for (int c = 0; c < 600; c++) begin
      bus.i_valid = ($urandom % 4) != 0;
      bus.i_data  = 17'($urandom);
      bus.i_ready = ($urandom % 3) != 0;
      shift_load  = ($urandom % 8) == 0;
      shift       = (($urandom % 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(18, 27));
      sat_clr     = ($urandom % 40) == 0;
      step();
      n_tests++;
      if (sat_cnt !== 16'(cnt_m)) begin
        n_fail++; $display("FAIL rand_cnt: cycle %0d cnt=%0d need %0d", c, sat_cnt, cnt_m);
      end
    end
    bus.i_valid = 1'b0; shift_load = 1'b0; sat_clr = 1'b0; bus.i_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    n_tests++;
    if (exp_q.size() != 0 || unexp_cnt != 0) begin
      n_fail++;
      $display("FAIL rand_drain: pending=%0d unexpected=%0d need 0/0", exp_q.size(), unexp_cnt);
    end
    n_tests++;
    if (sat_cnt !== 16'(cnt_m)) begin
      n_fail++; $display("FAIL rand_cnt_end: cnt=%0d need %0d", sat_cnt, cnt_m);
    end
    while (chk_o.size() > 0) begin
      o = chk_o.pop_front(); e = chk_e.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL rand_data: got sat=%b data=%h need sat=%b data=%h", o.sat, o.data, e.sat, e.data);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; shift_m = 0; cnt_m = 0; unexp_cnt = 0;
    rst_n = 1'b0; shift = '0; shift_load = 1'b0; sat_clr = 1'b0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
